// File: rtl/bellek_hakemi.sv
// Shares one memory port between instruction fetch and data accesses; grant is registered, so the request appears one cycle after arbitration.
// Requesters stay stalled until the memory strobes ready or the timeout completes the access; one idle cycle separates accesses.
module bellek_hakemi #(
  parameter int ACLIK_SINIRI = 4,
  parameter int ZAMAN_ASIMI  = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ib_istek_i,
  input  logic [31:0] ib_adres_i,
  output logic [31:0] ib_deger_o,
  output logic        ib_bekle_o,
  input  logic        vb_sec_i,
  input  logic        vb_yaz_gecerli_i,
  input  logic [31:0] vb_adr_i,
  input  logic [31:0] vb_veri_i,
  input  logic [3:0]  vb_veri_maske_i,
  output logic [31:0] vb_veri_o,
  output logic        vb_durdur_o,
  output logic        bel_istek_o,
  output logic        bel_yaz_o,
  output logic [31:0] bel_adr_o,
  output logic [31:0] bel_veri_o,
  output logic [3:0]  bel_maske_o,
  input  logic [31:0] bel_veri_i,
  input  logic        bel_hazir_i,
  output logic        hata_o
);
  localparam int AW = $clog2(ACLIK_SINIRI + 1);
  localparam int TW = (ZAMAN_ASIMI > 1) ? $clog2(ZAMAN_ASIMI) : 1;
  localparam logic [AW-1:0] ACLIK_UST = AW'(ACLIK_SINIRI);
  localparam logic [TW-1:0] ZAMAN_SON = TW'(ZAMAN_ASIMI - 1);

  typedef enum logic [1:0] {BOSTA, BUYRUK, VERI} durum_t;

  durum_t        durum, sonraki;
  logic [AW-1:0] aclik_sayac;
  logic [TW-1:0] zaman_sayac;
  logic [31:0]   ib_deger_q, vb_veri_q, okunan;
  logic          ib_kazanir, vb_kazanir, bitti, zaman_doldu;

  assign zaman_doldu = (zaman_sayac == ZAMAN_SON);
  assign okunan      = bel_hazir_i ? bel_veri_i : 32'h0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) durum <= BOSTA;
    else       durum <= sonraki;
  end

  always_comb begin
    sonraki    = durum;
    ib_kazanir = 1'b0;
    vb_kazanir = 1'b0;
    bitti      = 1'b0;
    hata_o     = 1'b0;
    case (durum)
      BOSTA: begin
        // Data normally wins; a starved fetch wins once the limit is reached.
        ib_kazanir = ib_istek_i && (!vb_sec_i || aclik_sayac == ACLIK_UST);
        vb_kazanir = vb_sec_i && !ib_kazanir;
        if (ib_kazanir)      sonraki = BUYRUK;
        else if (vb_kazanir) sonraki = VERI;
      end
      BUYRUK, VERI: begin
        bitti  = bel_hazir_i || zaman_doldu;
        hata_o = zaman_doldu && !bel_hazir_i;
        if (bitti) sonraki = BOSTA;
      end
      default: sonraki = BOSTA;
    endcase
  end

  assign ib_bekle_o  = ib_istek_i & ~((durum == BUYRUK) & bitti);
  assign vb_durdur_o = vb_sec_i & ~((durum == VERI) & bitti);
  assign ib_deger_o  = ((durum == BUYRUK) && bitti) ? okunan : ib_deger_q;
  assign vb_veri_o   = ((durum == VERI) && bitti && !bel_yaz_o) ? okunan : vb_veri_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bel_istek_o <= 1'b0;
      bel_yaz_o   <= 1'b0;
      bel_adr_o   <= 32'h0;
      bel_veri_o  <= 32'h0;
      bel_maske_o <= 4'b0000;
      ib_deger_q  <= 32'h0;
      vb_veri_q   <= 32'h0;
      aclik_sayac <= '0;
      zaman_sayac <= '0;
    end else begin
      if (durum == BOSTA) begin
        zaman_sayac <= '0;
        if (ib_kazanir) begin
          bel_istek_o <= 1'b1;
          bel_yaz_o   <= 1'b0;
          bel_adr_o   <= ib_adres_i;
          bel_veri_o  <= 32'h0;
          bel_maske_o <= 4'b0000;
        end else if (vb_kazanir) begin
          bel_istek_o <= 1'b1;
          bel_yaz_o   <= vb_yaz_gecerli_i;
          bel_adr_o   <= vb_adr_i;
          bel_veri_o  <= vb_veri_i;
          bel_maske_o <= vb_yaz_gecerli_i ? vb_veri_maske_i : 4'b0000;
        end
      end else begin
        zaman_sayac <= zaman_sayac + TW'(1);
        if (bitti) bel_istek_o <= 1'b0;
      end

      if ((durum == BUYRUK) && bitti)             ib_deger_q <= okunan;
      if ((durum == VERI) && bitti && !bel_yaz_o) vb_veri_q  <= okunan;

      if (!ib_istek_i || ib_kazanir)                   aclik_sayac <= '0;
      else if (vb_kazanir && aclik_sayac != ACLIK_UST) aclik_sayac <= aclik_sayac + AW'(1);
    end
  end
endmodule

// File: tb/tb_bellek_hakemi.sv
// Randomised bench for bellek_hakemi: requester and memory models feed a scoreboard checked by a cycle monitor.
module tb_bellek_hakemi;
  localparam int SINIR = 4;
  localparam int ZA    = 8;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        ib_istek_i, vb_sec_i, vb_yaz_gecerli_i, bel_hazir_i;
  logic [31:0] ib_adres_i, vb_adr_i, vb_veri_i, bel_veri_i;
  logic [3:0]  vb_veri_maske_i;
  logic [31:0] ib_deger_o, vb_veri_o, bel_adr_o, bel_veri_o;
  logic        ib_bekle_o, vb_durdur_o, bel_istek_o, bel_yaz_o, hata_o;
  logic [3:0]  bel_maske_o;

  bellek_hakemi #(.ACLIK_SINIRI(SINIR), .ZAMAN_ASIMI(ZA)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ib_istek_i(ib_istek_i), .ib_adres_i(ib_adres_i), .ib_deger_o(ib_deger_o), .ib_bekle_o(ib_bekle_o),
    .vb_sec_i(vb_sec_i), .vb_yaz_gecerli_i(vb_yaz_gecerli_i), .vb_adr_i(vb_adr_i), .vb_veri_i(vb_veri_i),
    .vb_veri_maske_i(vb_veri_maske_i), .vb_veri_o(vb_veri_o), .vb_durdur_o(vb_durdur_o),
    .bel_istek_o(bel_istek_o), .bel_yaz_o(bel_yaz_o), .bel_adr_o(bel_adr_o), .bel_veri_o(bel_veri_o),
    .bel_maske_o(bel_maske_o), .bel_veri_i(bel_veri_i), .bel_hazir_i(bel_hazir_i), .hata_o(hata_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int          n;
    logic        hata;
    logic [31:0] veri;
  } kayit_t;

  kayit_t exp_q[$];
  logic   kazanan_q[$];
  int     karsilastirilan = 0;
  int     uyusmayan = 0;
  int     ib_tamam = 0;
  int     mem_mod = 1;
  int     ib_olas = 0, vb_olas = 0;
  logic   ib_acik = 1'b0, vb_acik = 1'b0;

  task automatic kontrol(input string ad, input logic [159:0] gercek, input logic [159:0] beklenen);
    karsilastirilan++;
    if (gercek !== beklenen) begin
      uyusmayan++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", ad, gercek, beklenen, $time);
    end
  endtask

  // Fetch requester: holds address until its stall drops, then maybe issues another.
  initial begin : ib_surucu
    logic bitti;
    ib_istek_i = 1'b0;
    ib_adres_i = 32'h0;
    forever begin
      @(negedge clk_i);
      bitti = ib_istek_i && !ib_bekle_o;
      @(posedge clk_i);
      #1;
      if (rst_i) ib_istek_i = 1'b0;
      else if (!ib_istek_i || bitti) begin
        if (ib_acik && $urandom_range(99) < ib_olas) begin
          ib_istek_i = 1'b1;
          ib_adres_i = $urandom & 32'h7FFF_FFFC;
        end else ib_istek_i = 1'b0;
      end
    end
  end

  initial begin : vb_surucu
    logic bitti;
    vb_sec_i = 1'b0; vb_yaz_gecerli_i = 1'b0; vb_adr_i = 32'h0; vb_veri_i = 32'h0; vb_veri_maske_i = 4'h0;
    forever begin
      @(negedge clk_i);
      bitti = vb_sec_i && !vb_durdur_o;
      @(posedge clk_i);
      #1;
      if (rst_i) vb_sec_i = 1'b0;
      else if (!vb_sec_i || bitti) begin
        if (vb_acik && $urandom_range(99) < vb_olas) begin
          vb_sec_i         = 1'b1;
          vb_yaz_gecerli_i = 1'($urandom_range(1));
          vb_adr_i         = $urandom | 32'h8000_0000;
          vb_veri_i        = $urandom;
          vb_veri_maske_i  = 4'($urandom_range(15));
        end else vb_sec_i = 1'b0;
      end
    end
  end

  // Memory: picks a latency per access and records the expected completion.
  initial begin : bellek
    logic   aktif;
    int     say, L, r;
    kayit_t k;
    logic [31:0] D;
    aktif = 1'b0; say = 0; L = 0; D = 32'h0;
    k.n = 0; k.hata = 1'b0; k.veri = 32'h0;
    bel_hazir_i = 1'b0;
    bel_veri_i  = 32'h0;
    forever begin
      @(posedge clk_i);
      #1;
      bel_hazir_i = 1'b0;
      bel_veri_i  = $urandom;
      if (rst_i) aktif = 1'b0;
      else begin
        if (!aktif && bel_istek_o) begin
          aktif = 1'b1;
          say   = 0;
          D     = $urandom;
          r     = $urandom_range(15);
          if (mem_mod == 2 || (mem_mod == 0 && r == 0)) L = 0;
          else if (mem_mod == 3 || (mem_mod == 0 && r == 1)) L = ZA;
          else if (mem_mod == 1) L = 1;
          else L = $urandom_range(4, 1);
          k.n    = (L == 0) ? ZA : L;
          k.hata = (L == 0);
          k.veri = (L == 0) ? 32'h0 : D;
          exp_q.push_back(k);
        end
        if (aktif) begin
          say++;
          if (say == L) begin
            bel_hazir_i = 1'b1;
            bel_veri_i  = D;
          end
          if (say == k.n) aktif = 1'b0;
        end else if ($urandom_range(7) == 0) bel_hazir_i = 1'b1;
      end
    end
  end

  // Monitor: reference model of arbitration, completion timing and held read data.
  initial begin : izleyici
    logic busy, kim_ib, g_yaz, p_ib, p_vb, p_bosta, p_vb_yaz, bu_bosta, tamam, yaz_tamam;
    logic gr_ib, gr_vb, kabul_bek;
    logic [31:0] g_adr, g_veri, p_ib_adr, p_vb_adr, p_vb_veri, son_ib, son_vb, e_ibd, e_vbd;
    logic [3:0]  g_maske, p_vb_maske;
    int cyc, streak;
    kayit_t e;
    busy = 0; kim_ib = 0; g_yaz = 0; p_ib = 0; p_vb = 0; p_bosta = 1; p_vb_yaz = 0;
    g_adr = 0; g_veri = 0; g_maske = 0; p_ib_adr = 0; p_vb_adr = 0; p_vb_veri = 0; p_vb_maske = 0;
    son_ib = 0; son_vb = 0; cyc = 0; streak = 0;
    e.n = ZA; e.hata = 0; e.veri = 0;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        busy = 0; streak = 0; p_ib = 0; p_vb = 0; p_bosta = 1; son_ib = 0; son_vb = 0;
        exp_q.delete();
        kontrol("reset_outputs", 160'({bel_istek_o, bel_yaz_o, hata_o, bel_adr_o, bel_veri_o, bel_maske_o,
                                       ib_deger_o, vb_veri_o}), 160'(0));
        kontrol("reset_stalls", 160'({ib_bekle_o, vb_durdur_o}), 160'({ib_istek_i, vb_sec_i}));
        continue;
      end
      gr_ib = 0; gr_vb = 0; tamam = 0; yaz_tamam = 0;
      if (!busy) begin
        kabul_bek = p_bosta && (p_ib || p_vb);
        kontrol("grant", 160'(bel_istek_o), 160'(kabul_bek));
        if (bel_istek_o && kabul_bek) begin
          kim_ib = p_ib && (!p_vb || streak == SINIR);
          gr_ib = kim_ib; gr_vb = !kim_ib;
          kazanan_q.push_back(kim_ib);
          g_adr   = kim_ib ? p_ib_adr : p_vb_adr;
          g_yaz   = kim_ib ? 1'b0 : p_vb_yaz;
          g_maske = g_yaz ? p_vb_maske : 4'b0000;
          g_veri  = p_vb_veri;
          if (g_yaz) kontrol("grant_wdata", 160'(bel_veri_o), 160'(g_veri));
          kontrol("mem_record", 160'(exp_q.size() != 0), 160'(1));
          if (exp_q.size() != 0) e = exp_q.pop_front();
          busy = 1; cyc = 0;
        end
      end
      if (!p_ib || gr_ib) streak = 0;
      else if (gr_vb && streak < SINIR) streak++;

      bu_bosta = !busy;
      e_ibd = son_ib; e_vbd = son_vb;
      if (busy) begin
        cyc++;
        tamam = (cyc == e.n);
        kontrol("req_held", 160'(bel_istek_o), 160'(1));
        kontrol("bus_fields", 160'({bel_adr_o, bel_yaz_o, bel_maske_o}), 160'({g_adr, g_yaz, g_maske}));
        kontrol("hata", 160'(hata_o), 160'(tamam && e.hata));
        if (kim_ib) kontrol("stalls", 160'({ib_bekle_o, vb_durdur_o}), 160'({ib_istek_i && !tamam, vb_sec_i}));
        else        kontrol("stalls", 160'({ib_bekle_o, vb_durdur_o}), 160'({ib_istek_i, vb_sec_i && !tamam}));
        if (tamam) begin
          busy = 0;
          if (kim_ib) begin e_ibd = e.veri; son_ib = e.veri; ib_tamam++; end
          else if (!g_yaz) begin e_vbd = e.veri; son_vb = e.veri; end
          else yaz_tamam = 1;
        end
      end else begin
        kontrol("hata_idle", 160'(hata_o), 160'(0));
        kontrol("stalls_idle", 160'({ib_bekle_o, vb_durdur_o}), 160'({ib_istek_i, vb_sec_i}));
      end
      if (yaz_tamam) kontrol("read_data", 160'(ib_deger_o), 160'(e_ibd));
      else           kontrol("read_data", 160'({ib_deger_o, vb_veri_o}), 160'({e_ibd, e_vbd}));

      p_ib = ib_istek_i; p_vb = vb_sec_i; p_bosta = bu_bosta;
      p_ib_adr = ib_adres_i; p_vb_adr = vb_adr_i; p_vb_veri = vb_veri_i;
      p_vb_maske = vb_veri_maske_i; p_vb_yaz = vb_yaz_gecerli_i;
    end
  end

  task automatic bosalt();
    int n = 0;
    ib_acik = 1'b0;
    vb_acik = 1'b0;
    while ((ib_istek_i || vb_sec_i || bel_istek_o) && n < 100) begin
      @(posedge clk_i);
      #2;
      n++;
    end
    kontrol("drain", 160'(ib_istek_i || vb_sec_i || bel_istek_o), 160'(0));
  endtask

  initial begin : ana
    int n, once;
    logic [9:0] sira;
    rst_i = 1'b1;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    #1;
    rst_i = 1'b0;

    // Continuous contention with one-cycle memory.
    mem_mod = 1; ib_olas = 100; vb_olas = 100; ib_acik = 1; vb_acik = 1;
    n = 0;
    while (kazanan_q.size() < 10 && n < 200) begin @(posedge clk_i); n++; end
    kontrol("contention_grants", 160'(kazanan_q.size() >= 10), 160'(1));
    sira = '0;
    for (int i = 0; i < 10 && i < kazanan_q.size(); i++) sira[i] = kazanan_q[i];
    kontrol("grant_order", 160'(sira), 160'(10'b10000_10000));
    bosalt();

    mem_mod = 0; ib_olas = 40; vb_olas = 50; ib_acik = 1; vb_acik = 1;
    repeat (1500) @(posedge clk_i);
    bosalt();

    mem_mod = 2; vb_olas = 100; vb_acik = 1;
    repeat (40) @(posedge clk_i);
    bosalt();
    mem_mod = 1; vb_acik = 1;
    repeat (10) @(posedge clk_i);
    bosalt();

    mem_mod = 3; ib_olas = 100; vb_olas = 100; ib_acik = 1; vb_acik = 1;
    repeat (60) @(posedge clk_i);
    bosalt();

    // Reset in the middle of a data access.
    mem_mod = 2; vb_olas = 100; vb_acik = 1;
    n = 0;
    while (!bel_istek_o && n < 50) begin @(posedge clk_i); #2; n++; end
    kontrol("midreset_access", 160'(bel_istek_o), 160'(1));
    @(posedge clk_i);
    #3;
    vb_acik = 0;
    rst_i = 1'b1;
    #1;
    kontrol("midreset_async", 160'({bel_istek_o, bel_yaz_o, hata_o, bel_adr_o, bel_veri_o, bel_maske_o,
                                     ib_deger_o, vb_veri_o}), 160'(0));
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    #1;
    rst_i = 1'b0;
    mem_mod = 1; ib_olas = 100; ib_acik = 1;
    once = ib_tamam;
    n = 0;
    while (ib_tamam == once && n < 50) begin @(posedge clk_i); n++; end
    kontrol("fetch_after_reset", 160'(ib_tamam != once), 160'(1));
    bosalt();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", karsilastirilan, uyusmayan);
    $finish;
  end
endmodule

// File: doc/bellek_hakemi.md
# bellek_hakemi

Two-requester arbiter that shares one external memory port (QSPI or on-chip memory controller) between the core's instruction-fetch path (l1b side) and its data path (bib side). It sits between `cekirdek` and the memory controller. It registers the winning request onto the memory port, holds it until the memory acknowledges or a timeout fires, and then returns read data and releases the requester's stall.

## Interface
- `ACLIK_SINIRI`, 4: consecutive data grants allowed while a fetch is waiting; after that the next grant goes to fetch.
- `ZAMAN_ASIMI`, 1024: cycles a granted access may wait for `bel_hazir_i` before it is force-completed as an error.

- `clk_i`  in  1  single clock, rising edge
- `rst_i`  in  1  reset, asynchronous, active-high
- `ib_istek_i`  in  1  fetch request; held with `ib_adres_i` stable until `ib_bekle_o`=0
- `ib_adres_i`  in  32  fetch address
- `ib_deger_o`  out  32  fetched instruction word
- `ib_bekle_o`  out  1  fetch stall
- `vb_sec_i`  in  1  data request; held with address, data and mask stable until `vb_durdur_o`=0
- `vb_yaz_gecerli_i`  in  1  1 = write, 0 = read
- `vb_adr_i`  in  32  data address
- `vb_veri_i`  in  32  write data
- `vb_veri_maske_i`  in  4  byte enables for writes
- `vb_veri_o`  out  32  read data
- `vb_durdur_o`  out  1  data stall
- `bel_istek_o`  out  1  memory request, level
- `bel_yaz_o`  out  1  memory write
- `bel_adr_o`  out  32  memory address
- `bel_veri_o`  out  32  memory write data
- `bel_maske_o`  out  4  byte enables; 4'b0000 on reads
- `bel_veri_i`  in  32  memory read data, valid together with `bel_hazir_i`
- `bel_hazir_i`  in  1  one-cycle completion strobe from memory
- `hata_o`  out  1  one-cycle pulse on timeout completion

## Operation
- **States:**
  - BOSTA: idle.
  - BUYRUK: serving a fetch.
  - VERI: serving a data access.
- **BOSTA arbitration, evaluated each cycle:**
  - Only one request asserted: that request is granted.
  - Both asserted: data wins, unless `aclik_sayac` == `ACLIK_SINIRI`, in which case fetch wins.
- **Grant (BOSTA to BUYRUK or VERI):**
  - Registers `bel_adr_o`, `bel_yaz_o`, `bel_veri_o` and `bel_maske_o` from the winner.
  - Sets `bel_istek_o`=1.
  - Clears the timeout counter.
- **`aclik_sayac`** is $clog2(ACLIK_SINIRI+1) bits wide:
  - Increments on a data grant made while `ib_istek_i`=1, saturating at `ACLIK_SINIRI`.
  - Clears on a fetch grant and in any cycle where `ib_istek_i`=0.
- **In BUYRUK or VERI:**
  - `bel_*` outputs stay stable until completion.
  - Normal completion: `bel_hazir_i`=1.
  - Timeout completion: the timeout counter reaches `ZAMAN_ASIMI`-1 without `bel_hazir_i`.
  - The next state is always BOSTA, so there is one idle cycle between accesses.
- **Completion cycle (combinational):**
  - The served requester's stall is 0.
  - The read output equals `bel_veri_i` on normal completion, or 32'h0 on timeout.
  - The same value is captured at the edge. `ib_deger_o` and `vb_veri_o` hold the last captured value at all other times.
- **Stalls (combinational):**
  - `ib_bekle_o` = `ib_istek_i` & ~(BUYRUK & completion).
  - `vb_durdur_o` = `vb_sec_i` & ~(VERI & completion).
- **Timeout:** `hata_o`=1 for exactly the completion cycle of a timed-out access. Writes complete the same way; the write is treated as lost.
- **Protocol violations:**
  - `bel_hazir_i` in BOSTA is ignored.
  - A requester dropping its request mid-service does not abort the access; the access completes and its result is discarded.

## Timing
- **Reset values:**
  - `bel_istek_o`, `bel_yaz_o`, `hata_o` = 0.
  - `bel_adr_o`, `bel_veri_o`, `ib_deger_o`, `vb_veri_o` = 0.
  - `bel_maske_o` = 0.
  - State = BOSTA; `aclik_sayac` and the timeout counter = 0.
  - `ib_bekle_o` and `vb_durdur_o` follow their request inputs.
- **Minimum latency:** request asserted in cycle 0 in BOSTA, grant at the end of cycle 0, `bel_istek_o`=1 in cycle 1. With `bel_hazir_i`=1 in cycle 1, the stall drops in cycle 1 (one cycle of stall).
- **Throughput:** at most one access per 2 cycles.
- **Timeout:** with no `bel_hazir_i`, completion occurs in cycle `ZAMAN_ASIMI` after the grant, counting cycle 1 as the first.
- **`bel_hazir_i` coinciding with the timeout terminal count:** normal completion, no `hata_o`.
- **`rst_i` asserted mid-access:** all outputs take reset values immediately. `bel_istek_o` drops asynchronously and the access is abandoned.

## Test plan
- **Single fetch:** `ib_istek_i`=1, `ib_adres_i`=32'h0000_0040; memory answers `bel_hazir_i` with 32'h0010_0093 in the first request cycle.
  - `bel_adr_o`=32'h40, `bel_maske_o`=4'b0000.
  - `ib_bekle_o`=1 for 1 cycle, then 0 with `ib_deger_o`=32'h0010_0093.
- **Data write:** `vb_sec_i`=1, `vb_yaz_gecerli_i`=1, addr 32'h8000_0004, data 32'hCAFE_BABE, mask 4'b0011; memory answers with hazir after 3 cycles.
  - `bel_yaz_o`=1, `bel_maske_o`=4'b0011.
  - `vb_durdur_o` drops on the hazir cycle.
- **Contention and anti-starvation:** `ib_istek_i` and `vb_sec_i` held high continuously with `ACLIK_SINIRI`=4; every access gets hazir in 1 cycle.
  - Grant order: V V V V B V V V V B.
  - `aclik_sayac` counts 1..4 and clears on each B grant.
- **Timeout:** `ZAMAN_ASIMI`=8, data read, memory never sends hazir.
  - Completion in cycle 8 after the grant: `hata_o`=1 for 1 cycle, `vb_veri_o`=0, `vb_durdur_o`=0.
  - The next request is granted normally.
- **Hazir at terminal count:** `bel_hazir_i` arrives exactly at the timeout terminal count.
  - Normal completion with the memory data; `hata_o`=0.
- **Reset mid-access:** `rst_i` asserted while in VERI with `bel_istek_o`=1.
  - `bel_istek_o`=0 in the same cycle and every output at its reset value.
  - After release, a fetch request completes normally.
